dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache in the DM stage.
//  - Pipeline side: consumes dm_re_EX_DM / dm_we_EX_DM, the ALU address and the store data.
//  - Returns load data and d_rdy, the hit signal the decoder uses to freeze all pipeline stages.
//  - Memory side: fills and evicts 4-word lines to unified memory over a line-wide req/rdy handshake.

---
 rtl/dcache_ctrl.sv | 120 ++++++++++++
 tb/tb_dcache_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcache_ctrl : direct-mapped write-back/write-allocate data cache, DM stage
// Rev 1.0
// ---------------------------------------------------------------------------
module dcache_ctrl #(
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        d_rdy,
  output logic        mem_re,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [63:0] mem_wline,
  input  logic [63:0] mem_rline,
  input  logic        mem_rdy
);

  localparam int TAG_W = 16 - 2 - IDX_W;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, EVICT = 2'd1, FILL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [TAG_W-1:0]   tag_d  [LINES];
  logic [15:0]        data_q [LINES][4];
  logic [15:0]        data_d [LINES][4];

  logic [1:0]         off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               acc;
  logic               hit;

  assign off = addr[1:0];
  assign idx = addr[IDX_W+1:2];
  assign tag = addr[15:IDX_W+2];
  assign acc = re | we;
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  assign d_rdy     = (state_q == IDLE) && (!acc || hit);
  assign rdata     = data_q[idx][off];
  assign mem_we    = (state_q == EVICT);
  assign mem_re    = (state_q == FILL);
  // Eviction writes back to the victim's address, not the requested one.
  assign mem_addr  = mem_we ? {tag_q[idx], idx} : addr[15:2];
  assign mem_wline = {data_q[idx][3], data_q[idx][2], data_q[idx][1], data_q[idx][0]};

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (hit) begin
            // re && we together is handled as a store.
            if (we) begin
              data_d[idx][off] = wdata;
              dirty_d[idx]     = 1'b1;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = EVICT;
          end else begin
            state_d = FILL;
          end
        end
      end
      EVICT: begin
        if (mem_rdy) begin
          dirty_d[idx] = 1'b0;
          state_d      = FILL;
        end
      end
      FILL: begin
        if (mem_rdy) begin
          for (int w = 0; w < 4; w++) begin
            data_d[idx][w] = mem_rline[16*w +: 16];
          end
          tag_d[idx]   = tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid_q qualifies them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// tb_dcache_ctrl : table-driven vectors plus reset-during-fill and flush sequences.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we, mem_rdy;
  logic [15:0] addr, wdata, rdata;
  logic        d_rdy, mem_re, mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wline, mem_rline;

  int n_vec  = 0;
  int n_fail = 0;

  dcache_ctrl #(.IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .d_rdy(d_rdy), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wline(mem_wline), .mem_rline(mem_rline),
    .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re, we;
    logic [15:0] addr, wdata;
    logic        rdy;
    logic [63:0] rline;
    logic        d, mre, mwe;
    logic [13:0] maddr;
    logic        crd;
    logic [15:0] rd;
    logic        cwl;
    logic [63:0] wl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, w, input logic [15:0] a, wd,
                              input logic rdy, input logic [63:0] rl,
                              input logic d, mr, mw, input logic [13:0] ma,
                              input logic crd, input logic [15:0] rd,
                              input logic cwl, input logic [63:0] wl);
    vec_t v;
    v.re = r; v.we = w; v.addr = a; v.wdata = wd; v.rdy = rdy; v.rline = rl;
    v.d = d; v.mre = mr; v.mwe = mw; v.maddr = ma;
    v.crd = crd; v.rd = rd; v.cwl = cwl; v.wl = wl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  localparam logic [63:0] L1 = 64'h4444_3333_2222_BEEF;
  localparam logic [63:0] L2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] L3 = 64'h0005_0004_0003_0002;

  initial begin
    rst_n = 1'b0; re = 0; we = 0; addr = 0; wdata = 0; mem_rdy = 0; mem_rline = 0;

    // Test 1: cold miss to 0x0010, fill, then hit
    vq.push_back(mk(0,0,16'h0000,0,0,0,      1,0,0,14'h0,   0,0,0,0));
    vq.push_back(mk(1,0,16'h0010,0,0,0,      0,0,0,14'h0,   0,0,0,0));
    vq.push_back(mk(1,0,16'h0010,0,0,0,      0,1,0,14'h004, 0,0,0,0));
    vq.push_back(mk(1,0,16'h0010,0,1,L1,     0,1,0,14'h004, 0,0,0,0));
    vq.push_back(mk(1,0,16'h0010,0,0,0,      1,0,0,14'h0,   1,16'hBEEF,0,0));
    vq.push_back(mk(1,0,16'h0012,0,0,0,      1,0,0,14'h0,   1,16'h3333,0,0));
    // Test 2: store hit, read back
    vq.push_back(mk(0,1,16'h0011,16'h1234,0,0,1,0,0,14'h0,  0,0,0,0));
    vq.push_back(mk(1,0,16'h0011,0,0,0,      1,0,0,14'h0,   1,16'h1234,0,0));
    // Test 3: dirty conflict -> evict, fill, hit
    vq.push_back(mk(1,0,16'h0031,0,0,0,      0,0,0,14'h0,   0,0,0,0));
    vq.push_back(mk(1,0,16'h0031,0,0,0,      0,0,1,14'h004, 0,0,1,64'h4444_3333_1234_BEEF));
    vq.push_back(mk(1,0,16'h0031,0,1,0,      0,0,1,14'h004, 0,0,1,64'h4444_3333_1234_BEEF));
    vq.push_back(mk(1,0,16'h0031,0,1,L2,     0,1,0,14'h00C, 0,0,0,0));
    vq.push_back(mk(1,0,16'h0031,0,0,0,      1,0,0,14'h0,   1,16'hCCCC,0,0));
    // Test 4: clean conflict -> straight to fill, slow memory
    vq.push_back(mk(1,0,16'h0051,0,0,0,      0,0,0,14'h0,   0,0,0,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,16'h0051,0,0,0,    0,1,0,14'h014, 0,0,0,0));
    vq.push_back(mk(1,0,16'h0051,0,1,L3,     0,1,0,14'h014, 0,0,0,0));
    vq.push_back(mk(1,0,16'h0051,0,0,0,      1,0,0,14'h0,   1,16'h0003,0,0));
    // Test 6: stray mem_rdy while idle is ignored
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0,0,16'h0051,0,1,64'hFFFF_FFFF_FFFF_FFFF,1,0,0,14'h0,0,0,0,0));
    vq.push_back(mk(1,0,16'h0051,0,0,0,      1,0,0,14'h0,   1,16'h0003,0,0));
    // re && we together acts as a store
    vq.push_back(mk(1,1,16'h0051,16'h7777,0,0,1,0,0,14'h0,  0,0,0,0));
    vq.push_back(mk(1,0,16'h0051,0,0,0,      1,0,0,14'h0,   1,16'h7777,0,0));
    vq.push_back(mk(1,0,16'h0050,0,0,0,      1,0,0,14'h0,   1,16'h0002,0,0));

    // Reset state
    @(negedge clk); #1;
    chk("reset d_rdy", {63'd0, d_rdy}, 64'd1);
    chk("reset mem_re", {63'd0, mem_re}, 64'd0);
    chk("reset mem_we", {63'd0, mem_we}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      re = vq[i].re; we = vq[i].we; addr = vq[i].addr; wdata = vq[i].wdata;
      mem_rdy = vq[i].rdy; mem_rline = vq[i].rline;
      #1;
      chk($sformatf("v%0d d_rdy", i),  {63'd0, d_rdy},  {63'd0, vq[i].d});
      chk($sformatf("v%0d mem_re", i), {63'd0, mem_re}, {63'd0, vq[i].mre});
      chk($sformatf("v%0d mem_we", i), {63'd0, mem_we}, {63'd0, vq[i].mwe});
      if (vq[i].mre || vq[i].mwe)
        chk($sformatf("v%0d mem_addr", i), {50'd0, mem_addr}, {50'd0, vq[i].maddr});
      if (vq[i].crd)
        chk($sformatf("v%0d rdata", i), {48'd0, rdata}, {48'd0, vq[i].rd});
      if (vq[i].cwl)
        chk($sformatf("v%0d mem_wline", i), mem_wline, vq[i].wl);
    end

    // Test 5: reset asserted mid-FILL
    @(negedge clk); re = 1; we = 0; addr = 16'h0000; mem_rdy = 0; #1;
    chk("s5 miss d_rdy", {63'd0, d_rdy}, 64'd0);
    @(negedge clk); #1;
    chk("s5 fill mem_re", {63'd0, mem_re}, 64'd1);
    #2 rst_n = 1'b0; #1;
    chk("s5 rst mem_re", {63'd0, mem_re}, 64'd0);
    chk("s5 rst mem_we", {63'd0, mem_we}, 64'd0);
    chk("s5 rst d_rdy", {63'd0, d_rdy}, 64'd0);
    @(negedge clk); rst_n = 1'b1; addr = 16'h0010; #1;
    chk("s5 remiss d_rdy", {63'd0, d_rdy}, 64'd0);
    @(negedge clk); #1;
    chk("s5 no evict", {63'd0, mem_we}, 64'd0);
    chk("s5 refill mem_re", {63'd0, mem_re}, 64'd1);
    chk("s5 refill addr", {50'd0, mem_addr}, 64'h4);
    // Flush: access drops mid-FILL, line still installed
    @(negedge clk); re = 0; mem_rdy = 1; mem_rline = 64'h0000_0000_0000_DEAD; #1;
    chk("flush mem_re held", {63'd0, mem_re}, 64'd1);
    @(negedge clk); mem_rdy = 0; #1;
    chk("flush idle d_rdy", {63'd0, d_rdy}, 64'd1);
    chk("flush idle mem_re", {63'd0, mem_re}, 64'd0);
    @(negedge clk); re = 1; addr = 16'h0010; #1;
    chk("flush hit d_rdy", {63'd0, d_rdy}, 64'd1);
    chk("flush hit rdata", {48'd0, rdata}, 64'hDEAD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
